// File: rtl/mult_err_monitor_if.sv
// Sample stream and result bus between the approximate-multiplier test harness and mult_err_monitor.
interface mult_err_monitor_if #(
    parameter int unsigned ACC_W = 32
);
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       A;
    logic [7:0]       B;
    logic [15:0]      R;
    logic             busy;
    logic             done;
    logic [ACC_W-1:0] err_sum;
    logic [ACC_W-1:0] bias_sum;
    logic [15:0]      err_max;
    logic [15:0]      err_cnt;

    modport master (
        output start, in_valid, A, B, R,
        input  in_ready, busy, done, err_sum, bias_sum, err_max, err_cnt
    );

    modport slave (
        input  start, in_valid, A, B, R,
        output in_ready, busy, done, err_sum, bias_sum, err_max, err_cnt
    );
endinterface

// File: rtl/mult_err_monitor.sv
// Windowed error statistics for an 8x8 approximate multiplier: recomputes A*B and
// accumulates |err| sum, signed bias, max |err| and nonzero-error count over SAMPLES products.
module mult_err_monitor #(
    parameter int unsigned SAMPLES = 256,
    parameter int unsigned ACC_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mult_err_monitor_if.slave    bus
);
    localparam int unsigned SW = ACC_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        drain_q, drain_d;
    logic [15:0] acc_cnt_q, acc_cnt_d;
    logic        in_ready_q, in_ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        accept, clear;

    logic        s1_vld_q, s1_vld_d;
    logic [15:0] s1_exact_q, s1_exact_d;
    logic [15:0] s1_r_q, s1_r_d;

    logic               s2_vld_q, s2_vld_d;
    logic signed [16:0] s2_diff_q, s2_diff_d;
    logic [15:0]        s2_abs_q, s2_abs_d;
    logic               s2_nz_q, s2_nz_d;

    logic [ACC_W-1:0]        err_sum_q, err_sum_d;
    logic signed [ACC_W-1:0] bias_sum_q, bias_sum_d;
    logic [15:0]             err_max_q, err_max_d;
    logic [15:0]             err_cnt_q, err_cnt_d;

    logic [SW-1:0]        esum;
    logic signed [SW-1:0] bsum;

    // Window control FSM; status outputs are registered from the next state
    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        acc_cnt_d = acc_cnt_q;
        accept    = 1'b0;
        clear     = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d   = S_RUN;
                    acc_cnt_d = '0;
                    clear     = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.in_valid && in_ready_q) begin
                    accept    = 1'b1;
                    acc_cnt_d = acc_cnt_q + 16'd1;
                    if (acc_cnt_q == 16'(SAMPLES - 1)) begin
                        state_d = S_DRAIN;
                        drain_d = 1'b0;
                    end
                end
            end
            S_DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d = (state_d == S_RUN);
        busy_d     = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d     = (state_d == S_DONE);
    end

    // Three-stage datapath: exact product, signed difference, accumulate
    always_comb begin
        s1_vld_d   = accept;
        s1_exact_d = s1_exact_q;
        s1_r_d     = s1_r_q;
        if (accept) begin
            s1_exact_d = 16'(bus.A) * 16'(bus.B);
            s1_r_d     = bus.R;
        end

        s2_vld_d  = s1_vld_q;
        s2_diff_d = s2_diff_q;
        s2_abs_d  = s2_abs_q;
        s2_nz_d   = s2_nz_q;
        if (s1_vld_q) begin
            s2_diff_d = $signed(17'(s1_exact_q) - 17'(s1_r_q));
            s2_abs_d  = s2_diff_d[16] ? 16'(-s2_diff_d) : s2_diff_d[15:0];
            s2_nz_d   = (s2_diff_d != 17'sd0);
        end

        // Widened sums expose overflow in the top bit for clamping
        esum = SW'(err_sum_q) + SW'(s2_abs_q);
        bsum = SW'(bias_sum_q) + SW'(s2_diff_q);

        err_sum_d  = err_sum_q;
        bias_sum_d = bias_sum_q;
        err_max_d  = err_max_q;
        err_cnt_d  = err_cnt_q;
        if (clear) begin
            err_sum_d  = '0;
            bias_sum_d = '0;
            err_max_d  = '0;
            err_cnt_d  = '0;
        end else if (s2_vld_q) begin
            err_sum_d = esum[ACC_W] ? {ACC_W{1'b1}} : esum[ACC_W-1:0];
            if (bsum[ACC_W] != bsum[ACC_W-1])
                bias_sum_d = bsum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            else
                bias_sum_d = bsum[ACC_W-1:0];
            if (s2_abs_q > err_max_q) err_max_d = s2_abs_q;
            err_cnt_d = err_cnt_q + 16'(s2_nz_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            drain_q    <= 1'b0;
            acc_cnt_q  <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_exact_q <= '0;
            s1_r_q     <= '0;
            s2_vld_q   <= 1'b0;
            s2_diff_q  <= '0;
            s2_abs_q   <= '0;
            s2_nz_q    <= 1'b0;
            err_sum_q  <= '0;
            bias_sum_q <= '0;
            err_max_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            acc_cnt_q  <= acc_cnt_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            s1_vld_q   <= s1_vld_d;
            s1_exact_q <= s1_exact_d;
            s1_r_q     <= s1_r_d;
            s2_vld_q   <= s2_vld_d;
            s2_diff_q  <= s2_diff_d;
            s2_abs_q   <= s2_abs_d;
            s2_nz_q    <= s2_nz_d;
            err_sum_q  <= err_sum_d;
            bias_sum_q <= bias_sum_d;
            err_max_q  <= err_max_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err_sum  = err_sum_q;
    assign bus.bias_sum = bias_sum_q;
    assign bus.err_max  = err_max_q;
    assign bus.err_cnt  = err_cnt_q;
endmodule

// File: tb/tb_mult_err_monitor.sv
// Directed bench for mult_err_monitor: four instances with different window/width settings share one sample stream.
module tb_mult_err_monitor;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  A, B;
    logic [15:0] R;
    logic        start1, start3, start4, starts;
    int          checks;
    int          errors;

    mult_err_monitor_if #(.ACC_W(32)) if1 ();
    mult_err_monitor_if #(.ACC_W(32)) if3 ();
    mult_err_monitor_if #(.ACC_W(32)) if4 ();
    mult_err_monitor_if #(.ACC_W(17)) ifs ();

    assign if1.start = start1;  assign if1.in_valid = in_valid;
    assign if1.A = A;  assign if1.B = B;  assign if1.R = R;
    assign if3.start = start3;  assign if3.in_valid = in_valid;
    assign if3.A = A;  assign if3.B = B;  assign if3.R = R;
    assign if4.start = start4;  assign if4.in_valid = in_valid;
    assign if4.A = A;  assign if4.B = B;  assign if4.R = R;
    assign ifs.start = starts;  assign ifs.in_valid = in_valid;
    assign ifs.A = A;  assign ifs.B = B;  assign ifs.R = R;

    mult_err_monitor #(.SAMPLES(1), .ACC_W(32)) dut1  (.clk(clk), .rst(rst), .bus(if1));
    mult_err_monitor #(.SAMPLES(3), .ACC_W(32)) dut3  (.clk(clk), .rst(rst), .bus(if3));
    mult_err_monitor #(.SAMPLES(4), .ACC_W(32)) dut4  (.clk(clk), .rst(rst), .bus(if4));
    mult_err_monitor #(.SAMPLES(3), .ACC_W(17)) dut_s (.clk(clk), .rst(rst), .bus(ifs));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] r);
        in_valid = 1'b1; A = a; B = b; R = r;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++; if (if4.busy !== 1'b0 || if4.done !== 1'b0 || if4.in_ready !== 1'b0) begin errors++;
            $display("FAIL reset_status got busy=%b done=%b rdy=%b exp 0 0 0", if4.busy, if4.done, if4.in_ready); end
        checks++; if (if4.err_sum !== 32'd0 || if4.bias_sum !== 32'd0 || if4.err_max !== 16'd0 || if4.err_cnt !== 16'd0) begin errors++;
            $display("FAIL reset_results got %0d %0d %0d %0d exp 0 0 0 0", if4.err_sum, if4.bias_sum, if4.err_max, if4.err_cnt); end
        checks++; if (ifs.err_sum !== 17'd0 || ifs.busy !== 1'b0) begin errors++;
            $display("FAIL reset_sat got sum=%0d busy=%b exp 0 0", ifs.err_sum, ifs.busy); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_exact();
        start4 = 1'b1; step(); start4 = 1'b0;
        checks++; if (if4.in_ready !== 1'b1 || if4.busy !== 1'b1) begin errors++;
            $display("FAIL exact_run_entry got rdy=%b busy=%b exp 1 1", if4.in_ready, if4.busy); end
        send(8'd3, 8'd5, 16'd15);
        send(8'd7, 8'd9, 16'd63);
        send(8'd255, 8'd255, 16'd65025);
        send(8'd0, 8'd200, 16'd0);
        checks++; if (if4.in_ready !== 1'b0 || if4.busy !== 1'b1 || if4.done !== 1'b0) begin errors++;
            $display("FAIL exact_drain got rdy=%b busy=%b done=%b exp 0 1 0", if4.in_ready, if4.busy, if4.done); end
        step();
        checks++; if (if4.done !== 1'b0) begin errors++;
            $display("FAIL exact_done_early got %b exp 0", if4.done); end
        step();
        checks++; if (if4.done !== 1'b1 || if4.busy !== 1'b0) begin errors++;
            $display("FAIL exact_done got done=%b busy=%b exp 1 0", if4.done, if4.busy); end
        checks++; if (if4.err_sum !== 32'd0 || if4.bias_sum !== 32'd0 || if4.err_max !== 16'd0 || if4.err_cnt !== 16'd0) begin errors++;
            $display("FAIL exact_results got %0d %0d %0d %0d exp 0 0 0 0", if4.err_sum, if4.bias_sum, if4.err_max, if4.err_cnt); end
    endtask

    task automatic test_extreme();
        logic [31:0] neg;
        neg = 32'hFFFF_0001;
        start4 = 1'b1; step(); start4 = 1'b0;
        for (int i = 0; i < 4; i++) send(8'd255, 8'd255, 16'd0);
        step(); step();
        checks++; if (if4.done !== 1'b1 || if4.err_sum !== 32'd260100 || if4.bias_sum !== 32'd260100) begin errors++;
            $display("FAIL extreme_sums got done=%b %0d %0d exp 1 260100 260100", if4.done, if4.err_sum, if4.bias_sum); end
        checks++; if (if4.err_max !== 16'd65025 || if4.err_cnt !== 16'd4) begin errors++;
            $display("FAIL extreme_max_cnt got %0d %0d exp 65025 4", if4.err_max, if4.err_cnt); end
        start1 = 1'b1; step(); start1 = 1'b0;
        send(8'd0, 8'd0, 16'd65535);
        checks++; if (if1.in_ready !== 1'b0 || if1.busy !== 1'b1) begin errors++;
            $display("FAIL single_drain got rdy=%b busy=%b exp 0 1", if1.in_ready, if1.busy); end
        step(); step();
        checks++; if (if1.done !== 1'b1 || if1.err_sum !== 32'd65535 || if1.bias_sum !== neg) begin errors++;
            $display("FAIL single_sums got done=%b %0d %h exp 1 65535 ffff0001", if1.done, if1.err_sum, if1.bias_sum); end
        checks++; if (if1.err_max !== 16'd65535 || if1.err_cnt !== 16'd1) begin errors++;
            $display("FAIL single_max_cnt got %0d %0d exp 65535 1", if1.err_max, if1.err_cnt); end
    endtask

    task automatic test_mixed();
        start3 = 1'b1; step(); start3 = 1'b0;
        send(8'd15, 8'd15, 16'd200);
        send(8'd10, 8'd10, 16'd110);
        send(8'd2, 8'd3, 16'd6);
        step(); step();
        checks++; if (if3.done !== 1'b1 || if3.err_sum !== 32'd35 || if3.bias_sum !== 32'd15) begin errors++;
            $display("FAIL mixed_sums got done=%b %0d %0d exp 1 35 15", if3.done, if3.err_sum, if3.bias_sum); end
        checks++; if (if3.err_max !== 16'd25 || if3.err_cnt !== 16'd2) begin errors++;
            $display("FAIL mixed_max_cnt got %0d %0d exp 25 2", if3.err_max, if3.err_cnt); end
    endtask

    task automatic test_saturation();
        starts = 1'b1; step(); starts = 1'b0;
        for (int i = 0; i < 3; i++) send(8'd255, 8'd255, 16'd0);
        step(); step();
        checks++; if (ifs.done !== 1'b1 || ifs.err_sum !== 17'd131071 || ifs.bias_sum !== 17'd65535) begin errors++;
            $display("FAIL sat_sums got done=%b %0d %0d exp 1 131071 65535", ifs.done, ifs.err_sum, ifs.bias_sum); end
        checks++; if (ifs.err_max !== 16'd65025 || ifs.err_cnt !== 16'd3) begin errors++;
            $display("FAIL sat_max_cnt got %0d %0d exp 65025 3", ifs.err_max, ifs.err_cnt); end
    endtask

    task automatic test_handshake();
        start3 = 1'b1; step(); start3 = 1'b0;
        send(8'd15, 8'd15, 16'd200);
        start3 = 1'b1; step(); start3 = 1'b0;
        step();
        send(8'd15, 8'd15, 16'd200);
        checks++; if (if3.in_ready !== 1'b1) begin errors++;
            $display("FAIL hs_ready_mid got %b exp 1", if3.in_ready); end
        send(8'd15, 8'd15, 16'd200);
        checks++; if (if3.in_ready !== 1'b0) begin errors++;
            $display("FAIL hs_ready_drop got %b exp 0", if3.in_ready); end
        start3 = 1'b1;
        send(8'd255, 8'd255, 16'd0);
        start3 = 1'b0;
        step();
        checks++; if (if3.done !== 1'b1 || if3.err_sum !== 32'd75 || if3.bias_sum !== 32'd75) begin errors++;
            $display("FAIL hs_sums got done=%b %0d %0d exp 1 75 75", if3.done, if3.err_sum, if3.bias_sum); end
        checks++; if (if3.err_max !== 16'd25 || if3.err_cnt !== 16'd3) begin errors++;
            $display("FAIL hs_max_cnt got %0d %0d exp 25 3", if3.err_max, if3.err_cnt); end
    endtask

    task automatic test_reset_mid();
        start3 = 1'b1; step(); start3 = 1'b0;
        send(8'd255, 8'd255, 16'd0);
        send(8'd255, 8'd255, 16'd0);
        rst = 1'b1;
        #1;
        checks++; if (if3.busy !== 1'b0 || if3.in_ready !== 1'b0 || if3.done !== 1'b0) begin errors++;
            $display("FAIL rstmid_status got busy=%b rdy=%b done=%b exp 0 0 0", if3.busy, if3.in_ready, if3.done); end
        checks++; if (if3.err_sum !== 32'd0 || if3.bias_sum !== 32'd0 || if3.err_max !== 16'd0 || if3.err_cnt !== 16'd0) begin errors++;
            $display("FAIL rstmid_results got %0d %0d %0d %0d exp 0 0 0 0", if3.err_sum, if3.bias_sum, if3.err_max, if3.err_cnt); end
        step();
        rst = 1'b0;
        step(); step();
        checks++; if (if3.err_sum !== 32'd0 || if3.busy !== 1'b0) begin errors++;
            $display("FAIL rstmid_flush got sum=%0d busy=%b exp 0 0", if3.err_sum, if3.busy); end
        test_mixed();
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; in_valid = 1'b0;
        A = '0; B = '0; R = '0;
        start1 = 1'b0; start3 = 1'b0; start4 = 1'b0; starts = 1'b0;
        checks = 0; errors = 0;
        test_reset();
        test_exact();
        test_extreme();
        test_mixed();
        test_saturation();
        test_handshake();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_err_monitor.md
# mult_err_monitor

Streaming error-statistics collector that sits directly downstream of the 8x8 approximate multiplier. It consumes each operand pair and its approximate product, recomputes the exact product internally, and accumulates error metrics over a window of SAMPLES products: absolute-error sum, signed bias sum, maximum absolute error, and error count. The team uses it to characterise multiplier configurations in hardware without off-chip logging.

## Interface
- SAMPLES, 256: products per measurement window; legal range 1..65535.
- ACC_W, 32: width of err_sum and bias_sum; ACC_W >= 17.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; opens a new window; honoured only in IDLE or DONE.
- in_valid  in  1  A/B/R valid.
- in_ready  out  1  high only in RUN.
- A  in  8  multiplicand, unsigned.
- B  in  8  multiplier, unsigned.
- R  in  16  approximate product from the multiplier under test.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE; results stable.
- err_sum  out  ACC_W  sum of |A*B - R|, unsigned, saturating.
- bias_sum  out  ACC_W  sum of (A*B - R), two's complement, saturating at signed limits.
- err_max  out  16  maximum |A*B - R| in the window.
- err_cnt  out  16  number of samples with A*B != R.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start -> RUN; clears err_sum, bias_sum, err_max, err_cnt, and the accept counter in the same edge.
  - RUN: a sample is accepted on each edge where in_valid && in_ready. Accepting the SAMPLES-th sample -> DRAIN.
  - DRAIN: lasts exactly 2 cycles while the pipeline empties -> DONE.
  - DONE: holds results until the next start.
  - start in RUN or DRAIN is ignored.
- Pipeline:
  - S1 registers exact = A*B (16 bits) and R on accept, with a valid bit.
  - S2 registers diff = exact - R (17-bit signed, range -65535..65025), |diff| (16 bits), and nz = (diff != 0).
  - S3 updates the accumulators when the S2 valid bit is set.
- Arithmetic:
  - err_sum += |diff|; clamps at 2^ACC_W-1.
  - bias_sum += sign-extended diff; clamps at 2^(ACC_W-1)-1 and -2^(ACC_W-1).
  - err_max = max(err_max, |diff|).
  - err_cnt += nz. Cannot overflow, because SAMPLES <= 65535.
- Pipeline valid bits are cleared by reset. They are not cleared by start, which is unreachable while the pipeline is non-empty.
- Reset mid-window: all state is discarded immediately. The FSM goes to IDLE and partial results are lost.

## Timing
- Reset values:
  - state IDLE.
  - in_ready, busy, done = 0.
  - err_sum, bias_sum, err_max, err_cnt = 0.
  - all pipeline registers and valid bits = 0.
- start sampled at edge e0 -> RUN after e0; in_ready=1 from the cycle following e0.
- in_ready is decoded from the state only. It has no combinational path from in_valid.
- Sample accepted at edge e -> its contribution is visible on the outputs after edge e+2.
- Last accept at edge et:
  - state is DRAIN after et.
  - in_ready=0 from the cycle after et.
  - state is DONE after et+2.
  - done=1 in the same cycle the final accumulator values appear.
- Gaps in in_valid simply stall acceptance. No timeout.
- Outputs are readable mid-window, but only the values held while done=1 are defined.
- SAMPLES=1: RUN lasts until the single accept, then DRAIN 2 cycles, then DONE.

## Test plan
- Exact stream, SAMPLES=4: four samples with R=A*B (e.g. 3*5, R=15) -> err_sum=0, bias_sum=0, err_max=0, err_cnt=0; done 2 cycles after the 4th accept.
- Mixed errors, SAMPLES=3: (15,15,R=200), (10,10,R=110), (2,3,R=6) -> err_sum=35, bias_sum=15, err_max=25, err_cnt=2.
- Extreme error, SAMPLES=4: four samples (255,255,R=0) -> err_sum=260100, bias_sum=260100, err_max=65025, err_cnt=4. One sample (0,0,R=65535) -> bias contribution -65535, err_max=65535.
- Saturation, ACC_W=17, SAMPLES=3: three samples (255,255,R=0) -> err_sum=131071, bias_sum=65535 (clamped).
- Handshake: in_valid toggled 1,0,0,1,1 with SAMPLES=3 -> exactly 3 accepts; in_ready drops the cycle after the 3rd accept. start pulsed during RUN -> ignored, counts unchanged.
- Reset mid-RUN after 2 accepts -> all outputs 0 and state IDLE. A new start and a full window then give correct results with no leftover contribution.
